// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and width helpers for the matrix-keypad
//                scanner and its row decoder.
//  Contents    : scan_state_t  - scanner FSM state encoding
//                key_code_w()  - width of a linear key code for a rows x cols
//                                matrix (never less than 1 bit)
//                cnt_w()       - width of a counter that counts 0..n-1
//                                (never less than 1 bit)
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    function automatic int key_code_w(input int rows, input int cols);
        int w;
        w = $clog2(rows * cols);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_scanner_row_onehot_enc.sv
`default_nettype none
// ============================================================================
//  Module      : row_onehot_enc
//  Description : Combinational classifier for a synchronised keypad row
//                vector. Reports whether exactly one row is active, whether
//                several are, and the index of the single active row.
//  Ports       : rs    in  ROWS         synchronised row vector
//                hit   out 1            exactly one bit of rs set
//                multi out 1            two or more bits of rs set
//                idx   out clog2(ROWS)  index of the set bit, 0 unless hit
//  Revision    : 1.0 - initial release
// ============================================================================
module row_onehot_enc #(
    parameter int ROWS = 4
) (
    input  logic [ROWS-1:0]         rs,
    output logic                    hit,
    output logic                    multi,
    output logic [$clog2(ROWS)-1:0] idx
);

    localparam int IDX_W = $clog2(ROWS);

    logic             seen;
    logic             many;
    logic [IDX_W-1:0] pos;

    always_comb begin
        seen = 1'b0;
        many = 1'b0;
        pos  = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (rs[i]) begin
                if (seen) begin
                    many = 1'b1;
                end
                seen = 1'b1;
                pos  = IDX_W'(i);
            end
        end
    end

    assign hit   = seen & ~many;
    assign multi = many;
    // The index is only meaningful for a clean single-row reading; force 0
    // otherwise so downstream never latches a stale or arbitrary position.
    assign idx   = hit ? pos : '0;

endmodule : row_onehot_enc
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Matrix-keypad scanner. Drives one column at a time,
//                synchronises the rows, debounces press and release and
//                emits a single-cycle key event with a linear key code.
//  Ports       : clk        in  1       system clock
//                rst        in  1       synchronous reset, active-high
//                row_in     in  ROWS    raw row lines (asynchronous)
//                col_out    out COLS    one-hot column drive
//                key_valid  out 1       pulse on accepted press
//                key_code   out KW      row*COLS + col of last accepted key
//                key_held   out 1       high while the accepted key is down
//                multi_err  out 1       pulse on a multi-row scan sample
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ROWS-1:0]                     row_in,
    output logic [COLS-1:0]                     col_out,
    output logic                                key_valid,
    output logic [key_code_w(ROWS, COLS)-1:0]   key_code,
    output logic                                key_held,
    output logic                                multi_err
);

    localparam int KW    = key_code_w(ROWS, COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = cnt_w(COLS);
    localparam int DIV_W = cnt_w(SCAN_DIV);
    localparam int DEB_W = cnt_w(DEBOUNCE_CYCLES);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);

    // ------------------------------------------------------------------
    // Row synchroniser
    // ------------------------------------------------------------------
    logic [ROWS-1:0] rs_meta_q;
    logic [ROWS-1:0] rs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_meta_q <= '0;
            rs_q      <= '0;
        end else begin
            rs_meta_q <= row_in;
            rs_q      <= rs_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Row decode
    // ------------------------------------------------------------------
    logic          hit;
    logic          multi;
    logic [RW-1:0] idx;

    row_onehot_enc #(
        .ROWS (ROWS)
    ) u_row_dec (
        .rs    (rs_q),
        .hit   (hit),
        .multi (multi),
        .idx   (idx)
    );

    // ------------------------------------------------------------------
    // Scanner state
    // ------------------------------------------------------------------
    scan_state_t       state_q;
    logic [DIV_W-1:0]  div_q;
    logic [DEB_W-1:0]  deb_q;
    logic [COLS-1:0]   col_q;
    logic [CW-1:0]     col_idx_q;
    logic [RW-1:0]     row_idx_q;
    logic [ROWS-1:0]   row_oh_q;
    logic              key_valid_q;
    logic [KW-1:0]     key_code_q;
    logic              key_held_q;
    logic              multi_err_q;

    logic [COLS-1:0]   col_d;
    logic [CW-1:0]     col_idx_d;
    logic [KW-1:0]     key_code_d;

    // Next column in scan order; the one-hot drive and its binary index are
    // kept in lockstep so the key code needs no one-hot-to-binary encoder.
    always_comb begin
        col_d     = {col_q[COLS-2:0], col_q[COLS-1]};
        col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
        key_code_d = KW'(int'(row_idx_q) * COLS + int'(col_idx_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            div_q       <= '0;
            deb_q       <= '0;
            col_q       <= COLS'(1);
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            row_oh_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            multi_err_q <= 1'b0;

            unique case (state_q)
                SCAN: begin
                    // Rows are only examined on the last cycle of a column
                    // window, so the synchroniser has seen the new column.
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (hit) begin
                            row_idx_q <= idx;
                            row_oh_q  <= rs_q;
                            deb_q     <= '0;
                            state_q   <= DEBOUNCE;
                        end else begin
                            if (multi) begin
                                multi_err_q <= 1'b1;
                            end
                            col_q     <= col_d;
                            col_idx_q <= col_idx_d;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (rs_q == row_oh_q) begin
                        if (deb_q == DEB_LAST) begin
                            key_valid_q <= 1'b1;
                            key_code_q  <= key_code_d;
                            key_held_q  <= 1'b1;
                            state_q     <= HELD;
                        end else begin
                            deb_q <= deb_q + 1'b1;
                        end
                    end else begin
                        // Bounce or a second row: abandon this key quietly
                        // and carry on scanning from the next column.
                        col_q     <= col_d;
                        col_idx_q <= col_idx_d;
                        div_q     <= '0;
                        state_q   <= SCAN;
                    end
                end

                HELD: begin
                    if (rs_q == '0) begin
                        deb_q   <= '0;
                        state_q <= RELEASE;
                    end
                end

                RELEASE: begin
                    if (rs_q == '0) begin
                        if (deb_q == DEB_LAST) begin
                            key_held_q <= 1'b0;
                            col_q      <= col_d;
                            col_idx_q  <= col_idx_d;
                            div_q      <= '0;
                            state_q    <= SCAN;
                        end else begin
                            deb_q <= deb_q + 1'b1;
                        end
                    end else begin
                        state_q <= HELD;
                    end
                end

                default: begin
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign col_out   = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign multi_err = multi_err_q;

endmodule : keypad_scanner
`default_nettype wire
